fetch_btb: RTL
==============

// Module: fetch_btb
// PURPOSE
//  Parametrised fetch stage with a direct-mapped branch target buffer (BTB) holding per-entry saturating counters.
//  Generates the fetch PC and drives the instruction-memory handshake.
//  Predicts next PC as BTB target or PC+2; accepts redirects and training updates from execute.
//  Sits between the PC source and the IF/ID pipeline register.
// PARAMETERS
//  BTB_DEPTH  16       number of BTB entries; power of 2, >=2; IDX_W = log2(BTB_DEPTH)
//  CTR_W      2        saturating-counter width, >=1; predict taken when counter MSB = 1
//  RESET_PC   16'h0000 PC value loaded on reset
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  hold         in   1   pipeline hold (hazard/halt): PC frozen, no new request
//  redirect     in   1   execute-stage mispredict/jump: refetch from redirect_pc
//  redirect_pc  in   16  corrected PC
//  upd_valid    in   1   BTB training strobe (resolved branch)
//  upd_pc       in   16  PC of resolved branch
//  upd_target   in   16  resolved branch target
//  upd_taken    in   1   resolved direction
//  imem_rd      out  1   instruction-memory read request
//  imem_addr    out  16  instruction-memory address (= current PC)
//  imem_data    in   16  instruction from memory
//  imem_done    in   1   memory read complete this cycle
//  instr_out    out  16  fetched instruction to IF/ID
//  instr_valid  out  1   instr_out/pc_out valid this cycle
//  pc_out       out  16  PC of instr_out
//  pc_plus2     out  16  pc_out + 2, mod 2^16
//  pred_taken   out  1   prediction for instr_out
//  pred_target  out  16  predicted next PC for instr_out
//  fetch_stall  out  1   = imem_rd & ~imem_done
//  err          out  1   misaligned-fetch error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): PC=RESET_PC; all BTB valid bits=0; outputs 0.
//  - imem_addr=PC; imem_rd = ~hold & ~redirect.
//  - Lookup (comb, on PC):
//    - index = PC[IDX_W:1]; tag = PC[15:IDX_W+1].
//    - hit = valid & tag match; pred_taken = hit & ctr[CTR_W-1].
//    - pred_target = pred_taken ? btb_target : PC+2.
//  - Fetch accept = imem_rd & imem_done:
//    - instr_valid=1, instr_out=imem_data, pc_out=PC.
//    - PC <= pred_target next edge.
//  - Else instr_valid=0 and instr_out=16'h0800 (NOP); PC unchanged.
//  - Priority: redirect > hold > accept.
//    - Redirect: PC <= redirect_pc next edge; any same-cycle response is squashed (instr_valid=0).
//    - Redirect latency: target is presented on imem_addr 1 cycle after assertion.
//  - Update (on upd_valid; written at clock edge):
//    - Hit: ctr saturating +1 if taken, -1 if not (clamp at 0 and 2^CTR_W-1).
//    - Hit and taken: target <= upd_target.
//    - Miss and taken: allocate entry (valid=1, tag, target); ctr = 1<<(CTR_W-1) (weakly taken).
//    - Miss and not taken: no change.
//  - Same-cycle lookup and update to one index: lookup sees old contents; update lands at the edge.
//  - PC arithmetic wraps: 16'hFFFE + 2 = 16'h0000.
//  - Reset mid-fetch: outstanding request abandoned; memory response ignored until imem_rd re-asserts.
// CONFIGURATION
//  FETCH_ALIGN_ERR_EN:
//  - Defined: err=1 on any cycle where imem_rd & PC[0]=1.
//    - Such a fetch still completes, but instr_out forced to 16'h0800 and pred_taken=0.
//    - No BTB lookup or allocate for odd upd_pc.
//  - Undefined: err tied 0; PC[0] ignored.
// TESTING
//  - Reset, imem_done=1 every cycle, cold BTB -> pc_out 0,2,4,6; pred_taken=0 throughout.
//  - upd_valid with pc=0x0004, target=0x0040, taken=1; then refetch 0x0004 -> pred_taken=1, next pc_out=0x0040; ctr=2.
//  - 3 not-taken updates on 0x0004 -> ctr 1, 0, 0 (saturate); fetch 0x0004 -> next pc_out=0x0006.
//  - imem_done low 3 cycles at PC=0x0010 -> fetch_stall=1 x3, PC held; accepted on 4th cycle.
//  - redirect=1, redirect_pc=0x0100 with imem_done=1 -> instr_valid=0 that cycle; next imem_addr=0x0100.
//  - Macro defined, redirect_pc=0x0003 -> err=1, instr_out=0x0800; macro undefined -> err=0.

Source files
------------

// File: rtl/fetch_btb.sv
// fetch_btb: fetch-stage PC generator with a direct-mapped BTB of saturating counters.
// Define FETCH_ALIGN_ERR_EN to flag odd-PC fetches and keep them out of the BTB.
module fetch_btb #(
    parameter int          BTB_DEPTH = 16,
    parameter int          CTR_W     = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    output logic        fetch_stall,
    output logic        err
);
    localparam int               IDX_W    = $clog2(BTB_DEPTH);
    localparam int               TAG_W    = 15 - IDX_W;
    localparam logic [15:0]      NOP      = 16'h0800;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
`ifdef FETCH_ALIGN_ERR_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic [15:0]      pc_q, pc_d;
    logic [BTB_DEPTH-1:0] btbValid_q;
    logic [TAG_W-1:0] btbTag_q    [BTB_DEPTH];
    logic [15:0]      btbTarget_q [BTB_DEPTH];
    logic [CTR_W-1:0] btbCtr_q    [BTB_DEPTH];

    logic [IDX_W-1:0] lkIdx, updIdx;
    logic [TAG_W-1:0] lkTag, updTag;
    logic             lkHit, updHit, oddPc, updOdd, updEn;
    logic             predTaken, accept;
    logic [15:0]      pcPlus2, predTarget;
    logic [CTR_W-1:0] updCtrOld, newCtr;
    logic             ctrWrEn, tgtWrEn, allocEn;

    assign oddPc  = ALIGN_EN & pc_q[0];
    assign updOdd = ALIGN_EN & upd_pc[0];

    assign lkIdx      = pc_q[IDX_W:1];
    assign lkTag      = pc_q[15:IDX_W+1];
    assign lkHit      = btbValid_q[lkIdx] && (btbTag_q[lkIdx] == lkTag);
    assign predTaken  = lkHit & btbCtr_q[lkIdx][CTR_W-1] & ~oddPc;
    assign pcPlus2    = pc_q + 16'd2;
    assign predTarget = predTaken ? btbTarget_q[lkIdx] : pcPlus2;

    assign updIdx    = upd_pc[IDX_W:1];
    assign updTag    = upd_pc[15:IDX_W+1];
    assign updHit    = btbValid_q[updIdx] && (btbTag_q[updIdx] == updTag);
    assign updCtrOld = btbCtr_q[updIdx];
    assign updEn     = upd_valid & ~updOdd;

    // Training decision: saturate on hits, allocate weakly-taken on taken misses.
    always_comb begin
        ctrWrEn = 1'b0;
        tgtWrEn = 1'b0;
        allocEn = 1'b0;
        newCtr  = updCtrOld;
        if (updEn) begin
            if (updHit) begin
                ctrWrEn = 1'b1;
                if (upd_taken) begin
                    tgtWrEn = 1'b1;
                    if (updCtrOld != CTR_MAX) newCtr = updCtrOld + 1'b1;
                end else if (updCtrOld != '0) begin
                    newCtr = updCtrOld - 1'b1;
                end
            end else if (upd_taken) begin
                allocEn = 1'b1;
                newCtr  = CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btbValid_q <= '0;
        else if (allocEn) btbValid_q[updIdx] <= 1'b1;
    end

    // Payload needs no reset: it is only trusted once the valid bit is set.
    always_ff @(posedge clk) begin
        if (allocEn) btbTag_q[updIdx] <= updTag;
        if (allocEn || tgtWrEn) btbTarget_q[updIdx] <= upd_target;
        if (allocEn || ctrWrEn) btbCtr_q[updIdx] <= newCtr;
    end

    assign imem_rd = ~rst & ~hold & ~redirect;
    assign accept  = imem_rd & imem_done;

    always_comb begin
        pc_d = pc_q;
        if (redirect) pc_d = redirect_pc;
        else if (accept) pc_d = predTarget;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else pc_q <= pc_d;
    end

    assign imem_addr   = pc_q;
    assign instr_valid = accept;
    assign instr_out   = rst ? 16'h0000 : ((accept && !oddPc) ? imem_data : NOP);
    assign pc_out      = rst ? 16'h0000 : pc_q;
    assign pc_plus2    = rst ? 16'h0000 : pcPlus2;
    assign pred_taken  = ~rst & predTaken;
    assign pred_target = rst ? 16'h0000 : predTarget;
    assign fetch_stall = imem_rd & ~imem_done;
    assign err         = ALIGN_EN & imem_rd & pc_q[0];
endmodule
